// File: rtl/rs_scheduler_pkg.sv
// Shared types and constants for the reservation-station scheduler.
package rs_pkg;

    localparam int RS_TAG_W  = 5;
    localparam int RS_OP_W   = 10;
    localparam int RS_DATA_W = 32;

    // A source tag of zero means the operand value is already present.
    localparam logic [RS_TAG_W-1:0] TAG_READY = '0;

    // One station entry. Age is held separately in the age matrix.
    typedef struct packed {
        logic                 valid;
        logic [RS_OP_W-1:0]   op;
        logic [RS_TAG_W-1:0]  qj;
        logic [RS_TAG_W-1:0]  qk;
        logic [RS_DATA_W-1:0] vj;
        logic [RS_DATA_W-1:0] vk;
        logic [RS_DATA_W-1:0] a;
        logic [RS_TAG_W-1:0]  tag;
    } rs_entry_t;

    // True when a CDB broadcast satisfies a waiting source tag.
    function automatic logic tag_hit(input logic                cdb_valid,
                                     input logic [RS_TAG_W-1:0] cdb_tag,
                                     input logic [RS_TAG_W-1:0] q);
        return cdb_valid && (q != TAG_READY) && (q == cdb_tag);
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// Age matrix and oldest-ready selection for the reservation station.
// older_q[i][j] = 1 means entry i was dispatched before entry j.
module rs_age_select #(
    parameter int N_ENTRY = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_ENTRY-1:0] valid_i,
    input  logic [N_ENTRY-1:0] ready_i,
    input  logic [N_ENTRY-1:0] alloc_i,
    input  logic [N_ENTRY-1:0] free_i,
    input  logic               flush_i,
    output logic [N_ENTRY-1:0] grant_o
);

    logic [N_ENTRY-1:0] older_q [N_ENTRY];
    logic [N_ENTRY-1:0] older_d [N_ENTRY];
    logic [N_ENTRY-1:0] blocked;

    // An entry wins when no other ready entry is older than it.
    always_comb begin
        blocked = '0;
        grant_o = '0;
        for (int i = 0; i < N_ENTRY; i++) begin
            for (int j = 0; j < N_ENTRY; j++) begin
                if ((j != i) && ready_i[j] && older_q[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
            grant_o[i] = ready_i[i] && !blocked[i];
        end
    end

    // Freed entries drop out of the order; a new entry is younger than all survivors.
    always_comb begin
        for (int i = 0; i < N_ENTRY; i++) begin
            older_d[i] = older_q[i];
        end
        for (int i = 0; i < N_ENTRY; i++) begin
            if (free_i[i]) begin
                older_d[i] = '0;
                for (int j = 0; j < N_ENTRY; j++) begin
                    older_d[j][i] = 1'b0;
                end
            end
        end
        for (int k = 0; k < N_ENTRY; k++) begin
            if (alloc_i[k]) begin
                older_d[k] = '0;
                for (int j = 0; j < N_ENTRY; j++) begin
                    if (j != k) begin
                        older_d[j][k] = valid_i[j] && !free_i[j];
                    end
                end
            end
        end
        if (flush_i) begin
            for (int i = 0; i < N_ENTRY; i++) begin
                older_d[i] = '0;
            end
        end
    end

    // Age matrix register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRY; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ENTRY; i++) begin
                older_q[i] <= older_d[i];
            end
        end
    end

endmodule

// File: rtl/rs_scheduler.sv
// Reservation-station scheduler: buffers decoded instructions, captures
// operands from the CDB, and issues the oldest ready entry.
//
// Handshakes: dispatch occurs at the edge when disp_valid && disp_ready;
// issue occurs at the edge when issue_valid && issue_ready && !flush.
// Both ready/valid sides depend only on registered state.
module rs_scheduler
    import rs_pkg::*;
#(
    parameter int N_ENTRY = 4,
    parameter int TAG_W   = RS_TAG_W,
    parameter int OP_W    = RS_OP_W,
    localparam int CNT_W  = $clog2(N_ENTRY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [OP_W-1:0]  disp_op,
    input  logic [TAG_W-1:0] disp_qj,
    input  logic [TAG_W-1:0] disp_qk,
    input  logic [31:0]      disp_vj,
    input  logic [31:0]      disp_vk,
    input  logic [31:0]      disp_a,
    input  logic [TAG_W-1:0] disp_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [OP_W-1:0]  issue_op,
    output logic [31:0]      issue_vj,
    output logic [31:0]      issue_vk,
    output logic [31:0]      issue_a,
    output logic [TAG_W-1:0] issue_tag,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);

    rs_entry_t entries_q [N_ENTRY];
    rs_entry_t entries_d [N_ENTRY];
    rs_entry_t new_entry;
    rs_entry_t issue_sel;

    logic [CNT_W-1:0]   count_q, count_d;
    logic [N_ENTRY-1:0] valid_vec, ready_vec, grant;
    logic [N_ENTRY-1:0] alloc_oh, alloc_i, free_i;
    logic               alloc_found;
    logic               disp_fire, issue_fire;
    logic [RS_TAG_W-1:0] cdb_tag_s;

    assign cdb_tag_s  = RS_TAG_W'(cdb_tag);
    assign disp_ready = (count_q < CNT_W'(N_ENTRY));
    assign disp_fire  = disp_valid && disp_ready && !flush;
    assign issue_fire = issue_valid && issue_ready && !flush;
    assign alloc_i    = disp_fire  ? alloc_oh : '0;
    assign free_i     = issue_fire ? grant    : '0;
    assign count      = count_q;

    // Occupancy and operand-ready vectors from registered entries.
    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        for (int i = 0; i < N_ENTRY; i++) begin
            valid_vec[i] = entries_q[i].valid;
            ready_vec[i] = entries_q[i].valid &&
                           (entries_q[i].qj == TAG_READY) &&
                           (entries_q[i].qk == TAG_READY);
        end
    end

    // Lowest-index free entry receives the next dispatch.
    always_comb begin
        alloc_oh    = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < N_ENTRY; i++) begin
            if (!valid_vec[i] && !alloc_found) begin
                alloc_oh[i] = 1'b1;
                alloc_found = 1'b1;
            end
        end
    end

    // Build the incoming entry, capturing a same-cycle CDB result.
    always_comb begin
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.op    = RS_OP_W'(disp_op);
        new_entry.qj    = RS_TAG_W'(disp_qj);
        new_entry.qk    = RS_TAG_W'(disp_qk);
        new_entry.vj    = disp_vj;
        new_entry.vk    = disp_vk;
        new_entry.a     = disp_a;
        new_entry.tag   = RS_TAG_W'(disp_tag);
        if (tag_hit(cdb_valid, cdb_tag_s, RS_TAG_W'(disp_qj))) begin
            new_entry.vj = cdb_data;
            new_entry.qj = TAG_READY;
        end
        if (tag_hit(cdb_valid, cdb_tag_s, RS_TAG_W'(disp_qk))) begin
            new_entry.vk = cdb_data;
            new_entry.qk = TAG_READY;
        end
    end

    // Per-entry next state: wakeup, then issue free, then allocation; flush wins.
    always_comb begin
        for (int i = 0; i < N_ENTRY; i++) begin
            entries_d[i] = entries_q[i];
            if (entries_q[i].valid) begin
                if (tag_hit(cdb_valid, cdb_tag_s, entries_q[i].qj)) begin
                    entries_d[i].vj = cdb_data;
                    entries_d[i].qj = TAG_READY;
                end
                if (tag_hit(cdb_valid, cdb_tag_s, entries_q[i].qk)) begin
                    entries_d[i].vk = cdb_data;
                    entries_d[i].qk = TAG_READY;
                end
            end
            if (free_i[i]) begin
                entries_d[i].valid = 1'b0;
            end
            if (alloc_i[i]) begin
                entries_d[i] = new_entry;
            end
            if (flush) begin
                entries_d[i].valid = 1'b0;
            end
        end
    end

    // Occupancy count tracks dispatches minus issues.
    always_comb begin
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
        end
    end

    // Entry storage and count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            for (int i = 0; i < N_ENTRY; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < N_ENTRY; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    rs_age_select #(
        .N_ENTRY (N_ENTRY)
    ) u_age (
        .clk     (clk),
        .rst_n   (reset),
        .valid_i (valid_vec),
        .ready_i (ready_vec),
        .alloc_i (alloc_i),
        .free_i  (free_i),
        .flush_i (flush),
        .grant_o (grant)
    );

    // One-hot mux of the granted entry; all-zero when nothing is ready.
    always_comb begin
        issue_sel = '0;
        for (int i = 0; i < N_ENTRY; i++) begin
            if (grant[i]) begin
                issue_sel = entries_q[i];
            end
        end
    end

    assign issue_valid = |grant;
    assign issue_op    = OP_W'(issue_sel.op);
    assign issue_vj    = issue_sel.vj;
    assign issue_vk    = issue_sel.vk;
    assign issue_a     = issue_sel.a;
    assign issue_tag   = TAG_W'(issue_sel.tag);

endmodule

// File: tb/tb_rs_scheduler.sv
// Scoreboard bench for rs_scheduler: directed dispatch/CDB/flush/reset vectors.
module tb_rs_scheduler;
  localparam int N  = 4;
  localparam int TW = 5;
  localparam int OW = 10;
  localparam int CW = $clog2(N + 1);
  localparam int W  = OW + 96 + TW;

  logic          clk, reset;
  logic          disp_valid, disp_ready;
  logic [OW-1:0] disp_op;
  logic [TW-1:0] disp_qj, disp_qk, disp_tag;
  logic [31:0]   disp_vj, disp_vk, disp_a;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [31:0]   cdb_data;
  logic          issue_valid, issue_ready;
  logic [OW-1:0] issue_op;
  logic [31:0]   issue_vj, issue_vk, issue_a;
  logic [TW-1:0] issue_tag;
  logic          flush;
  logic [CW-1:0] count;

  logic [W-1:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  rs_scheduler #(.N_ENTRY(N), .TAG_W(TW), .OP_W(OW)) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_a(disp_a), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_a(issue_a), .issue_tag(issue_tag),
    .flush(flush), .count(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input logic [OW-1:0] op, input logic [31:0] vj,
                               input logic [31:0] vk, input logic [31:0] a,
                               input logic [TW-1:0] tag);
    exp_q.push_back({op, vj, vk, a, tag});
  endfunction

  // driver
  task automatic dispatch(input logic [OW-1:0] op, input logic [TW-1:0] qj,
                          input logic [TW-1:0] qk, input logic [31:0] vj,
                          input logic [31:0] vk, input logic [31:0] a,
                          input logic [TW-1:0] tag);
    disp_op = op; disp_qj = qj; disp_qk = qk;
    disp_vj = vj; disp_vk = vk; disp_a = a; disp_tag = tag;
    disp_valid = 1'b1;
    tick();
    disp_valid = 1'b0;
  endtask

  // monitor: every accepted issue must match the head of the expected queue
  always @(negedge clk) begin
    if (reset && issue_valid && issue_ready && !flush) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL issue_unexpected: got tag %0d expected no issue", issue_tag);
      end else begin
        check("issue_pkt", {issue_op, issue_vj, issue_vk, issue_a, issue_tag}, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0; disp_valid = 0; disp_op = '0; disp_qj = '0; disp_qk = '0;
    disp_vj = '0; disp_vk = '0; disp_a = '0; disp_tag = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0; issue_ready = 0; flush = 0;
    #3;
    check("rst_count", count, 0);
    check("rst_disp_ready", disp_ready, 1);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_issue_vj", issue_vj, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // single ready instruction issues next cycle
    issue_ready = 1'b1;
    push(10'h013, 32'd5, 32'd7, 32'd0, 5'd3);
    dispatch(10'h013, 5'd0, 5'd0, 32'd5, 32'd7, 32'd0, 5'd3);
    check("t1_issue_valid", issue_valid, 1);
    check("t1_issue_vj", issue_vj, 5);
    check("t1_issue_vk", issue_vk, 7);
    check("t1_issue_tag", issue_tag, 3);
    check("t1_count1", count, 1);
    tick();
    check("t1_count0", count, 0);
    issue_ready = 1'b0;

    // younger ready B bypasses waiting A; A wakes from CDB
    dispatch(10'h020, 5'd4, 5'd0, 32'd0, 32'h11, 32'h100, 5'd6);
    push(10'h021, 32'd1, 32'd2, 32'd0, 5'd7);
    dispatch(10'h021, 5'd0, 5'd0, 32'd1, 32'd2, 32'd0, 5'd7);
    check("t2_sel_b", issue_tag, 7);
    check("t2_count2", count, 2);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    check("t2_a_waiting", issue_valid, 0);
    cdb_valid = 1'b1; cdb_tag = 5'd4; cdb_data = 32'hDEAD;
    push(10'h020, 32'hDEAD, 32'h11, 32'h100, 5'd6);
    check("t2_no_forward", issue_valid, 0);
    tick();
    cdb_valid = 1'b0;
    check("t2_a_vj", issue_vj, 32'hDEAD);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    check("t2_count0", count, 0);

    // age order beats index order: D lands in entry 0, C in entry 1
    push(10'h030, 32'd3, 32'd4, 32'd0, 5'd10);
    dispatch(10'h030, 5'd0, 5'd0, 32'd3, 32'd4, 32'd0, 5'd10);
    dispatch(10'h031, 5'd9, 5'd0, 32'd0, 32'h22, 32'd0, 5'd11);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    dispatch(10'h032, 5'd9, 5'd0, 32'd0, 32'h33, 32'd0, 5'd12);
    check("t3_count2", count, 2);
    check("t3_none_ready", issue_valid, 0);
    cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 32'h99;
    push(10'h031, 32'h99, 32'h22, 32'd0, 5'd11);
    push(10'h032, 32'h99, 32'h33, 32'd0, 5'd12);
    tick();
    cdb_valid = 1'b0;
    check("t3_sel_c", issue_tag, 11);
    issue_ready = 1'b1;
    tick();
    check("t3_sel_d", issue_tag, 12);
    tick();
    issue_ready = 1'b0;
    check("t3_count0", count, 0);

    // dispatch/CDB bypass on qk
    cdb_valid = 1'b1; cdb_tag = 5'd2; cdb_data = 32'h55;
    push(10'h040, 32'h10, 32'h55, 32'd5, 5'd21);
    dispatch(10'h040, 5'd0, 5'd2, 32'h10, 32'd0, 32'd5, 5'd21);
    cdb_valid = 1'b0;
    check("t4_ready", issue_valid, 1);
    check("t4_vk", issue_vk, 32'h55);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    check("t4_count0", count, 0);

    // fill, ignored dispatch while full, flush
    for (int i = 0; i < N; i++) begin
      dispatch(10'h050 + 10'(i), 5'd1, 5'd0, 32'(i), 32'd0, 32'd0, 5'(13 + i));
    end
    check("t5_count4", count, 4);
    check("t5_full", disp_ready, 0);
    check("t5_none_ready", issue_valid, 0);
    disp_op = 10'h060; disp_qj = '0; disp_qk = '0; disp_tag = 5'd17; disp_valid = 1'b1;
    tick();
    disp_valid = 1'b0;
    check("t5_full_count", count, 4);
    check("t5_full_ignored", issue_valid, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_flush_count", count, 0);
    check("t5_flush_ready", disp_ready, 1);
    check("t5_flush_issue", issue_valid, 0);
    cdb_valid = 1'b1; cdb_tag = 5'd1; cdb_data = 32'h1;
    tick();
    cdb_valid = 1'b0;
    check("t5_flushed_gone", issue_valid, 0);
    flush = 1'b1; disp_valid = 1'b1; disp_tag = 5'd18;
    tick();
    flush = 1'b0; disp_valid = 1'b0;
    check("t5_flush_drop_cnt", count, 0);
    check("t5_flush_drop_iss", issue_valid, 0);

    // stable hold under backpressure, then asynchronous reset
    dispatch(10'h3FF, 5'd0, 5'd0, 32'hAAAA, 32'hBBBB, 32'hCCCC, 5'd20);
    for (int i = 0; i < 3; i++) begin
      check("t6_hold_tag", issue_tag, 20);
      check("t6_hold_vj", issue_vj, 32'hAAAA);
      tick();
    end
    #2 reset = 1'b0;
    #1;
    check("t6_arst_valid", issue_valid, 0);
    check("t6_arst_count", count, 0);
    check("t6_arst_vj", issue_vj, 0);
    check("t6_arst_ready", disp_ready, 1);
    tick();
    reset = 1'b1;
    tick();
    check("t6_post_rst", issue_valid, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
